// File: rtl/neopix_frame_sched.sv
// Double-buffer bank selector and refresh pacer between the SPI frame writer and the ws2812 serializer.
// Optional strip blanking after TIMEOUT_FRAMES idle refreshes is enabled by defining NEOPIX_BLANK_TIMEOUT_EN.
module neopix_frame_sched #(
    parameter int NUM_LEDS       = 256,
    parameter int SYSTEM_CLOCK   = 50000000,
    parameter int REFRESH_HZ     = 100,
    parameter int TIMEOUT_FRAMES = 100,
    localparam int CW            = $clog2(NUM_LEDS) + 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          wr_start,
    input  logic          wr_done,
    input  logic [CW-1:0] wr_count,
    output logic          wr_bank,
    input  logic          disp_ready,
    output logic          disp_bank,
    output logic [CW-1:0] disp_count,
    output logic          disp_start,
    output logic          pending,
    output logic          frame_drop
);

    localparam int PERIOD = SYSTEM_CLOCK / REFRESH_HZ;
    localparam int TW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    generate
        if (PERIOD < 2 || TIMEOUT_FRAMES < 1) begin : g_bad_cfg
            $error("neopix_frame_sched: refresh period must be >= 2 cycles and TIMEOUT_FRAMES >= 1");
        end
    endgenerate

    typedef enum logic {
        IDLE    = 1'b0,
        WRITING = 1'b1
    } wr_state_t;

    wr_state_t       state;
    wr_state_t       state_next;
    logic            writing;
    logic            frame_begin;
    logic            frame_complete;

    logic [TW-1:0]   tick_cnt;
    logic            tick_pend;
    logic [CW-1:0]   pend_count;
    logic [CW-1:0]   wr_count_clamped;
    logic            tick;
    logic            refresh_ev;
    logic            swap;
    logic            blank_now;

    // ------------------------------------------------------------------
    // Writer state machine
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (wr_start) begin
                    state_next = WRITING;
                end
            end
            WRITING: begin
                // A start that coincides with done is a restart, not a completion.
                if (wr_start) begin
                    state_next = WRITING;
                end else if (wr_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        writing        = 1'b0;
        frame_begin    = 1'b0;
        frame_complete = 1'b0;
        case (state)
            IDLE: begin
                frame_begin = wr_start;
            end
            WRITING: begin
                writing        = 1'b1;
                frame_complete = wr_done && !wr_start;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Refresh pacing and bank swap decision
    // ------------------------------------------------------------------
    assign tick             = (tick_cnt == TW'(PERIOD - 1));
    assign refresh_ev       = tick_pend && disp_ready;
    assign swap             = refresh_ev && pending && !writing;
    assign wr_count_clamped = (wr_count > CW'(NUM_LEDS)) ? CW'(NUM_LEDS) : wr_count;

`ifdef NEOPIX_BLANK_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_FRAMES + 1);

    logic [IW-1:0] idle_cnt;

    // Blank on the refresh that brings the idle count up to the limit.
    assign blank_now = refresh_ev && !swap && (idle_cnt == IW'(TIMEOUT_FRAMES - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            idle_cnt <= '0;
        end else if (swap) begin
            idle_cnt <= '0;
        end else if (refresh_ev && (idle_cnt != IW'(TIMEOUT_FRAMES))) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign blank_now = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tick_cnt   <= '0;
            tick_pend  <= 1'b0;
            disp_start <= 1'b0;
            disp_bank  <= 1'b0;
            wr_bank    <= 1'b1;
            disp_count <= '0;
            pending    <= 1'b0;
            pend_count <= '0;
            frame_drop <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

            // A new tick outranks the consuming refresh, so none is lost.
            if (tick) begin
                tick_pend <= 1'b1;
            end else if (refresh_ev) begin
                tick_pend <= 1'b0;
            end

            disp_start <= refresh_ev;

            if (swap) begin
                disp_bank  <= ~disp_bank;
                wr_bank    <= disp_bank;
                disp_count <= pend_count;
            end else if (blank_now) begin
                disp_count <= '0;
            end

            frame_drop <= 1'b0;
            if (swap) begin
                pending <= 1'b0;
            end else if (frame_begin && pending) begin
                pending    <= 1'b0;
                frame_drop <= 1'b1;
            end else if (frame_complete) begin
                pending    <= 1'b1;
                pend_count <= wr_count_clamped;
            end
        end
    end

endmodule

// File: tb/tb_neopix_frame_sched.sv
// Directed self-checking bench for neopix_frame_sched with a 10-cycle refresh period.
// Expected blanking behaviour follows NEOPIX_BLANK_TIMEOUT_EN when the bench is built with it.
module tb_neopix_frame_sched;

    localparam int NUM_LEDS = 256;
    localparam int CW       = $clog2(NUM_LEDS) + 1;
    localparam int BUDGET   = 100;

`ifdef NEOPIX_BLANK_TIMEOUT_EN
    localparam int EXP_BLANK_COUNT = 0;
`else
    localparam int EXP_BLANK_COUNT = 12;
`endif

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          wr_start = 1'b0;
    logic          wr_done = 1'b0;
    logic [CW-1:0] wr_count = '0;
    logic          wr_bank;
    logic          disp_ready = 1'b1;
    logic          disp_bank;
    logic [CW-1:0] disp_count;
    logic          disp_start;
    logic          pending;
    logic          frame_drop;

    int checks = 0;
    int errors = 0;

    neopix_frame_sched #(
        .NUM_LEDS      (NUM_LEDS),
        .SYSTEM_CLOCK  (1000),
        .REFRESH_HZ    (100),
        .TIMEOUT_FRAMES(3)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .wr_start  (wr_start),
        .wr_done   (wr_done),
        .wr_count  (wr_count),
        .wr_bank   (wr_bank),
        .disp_ready(disp_ready),
        .disp_bank (disp_bank),
        .disp_count(disp_count),
        .disp_start(disp_start),
        .pending   (pending),
        .frame_drop(frame_drop)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET      = 1'b1;
        wr_start   = 1'b0;
        wr_done    = 1'b0;
        disp_ready = 1'b1;
        step();
        step();
        RESET = 1'b0;
    endtask

    // Steps until disp_start is seen; n is the number of edges taken.
    task automatic wait_disp_start(input string tag, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (disp_start !== 1'b1 && n < BUDGET);
        checks++;
        if (disp_start !== 1'b1) begin
            errors++;
            $display("FAIL %s: disp_start not seen within %0d cycles", tag, BUDGET);
        end
    endtask

    task automatic write_frame(input int cnt);
        wr_start = 1'b1;
        step();
        wr_start = 1'b0;
        step();
        wr_done  = 1'b1;
        wr_count = CW'(cnt);
        step();
        wr_done = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        checks++; if (disp_bank !== 1'b0) begin errors++; $display("FAIL rst_disp_bank: got %0b want 0", disp_bank); end
        checks++; if (wr_bank !== 1'b1) begin errors++; $display("FAIL rst_wr_bank: got %0b want 1", wr_bank); end
        checks++; if (disp_count !== '0) begin errors++; $display("FAIL rst_disp_count: got %0d want 0", disp_count); end
        checks++; if (disp_start !== 1'b0) begin errors++; $display("FAIL rst_disp_start: got %0b want 0", disp_start); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rst_pending: got %0b want 0", pending); end
        checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL rst_frame_drop: got %0b want 0", frame_drop); end
        wait_disp_start("first_refresh", n);
        checks++; if (n !== 11) begin errors++; $display("FAIL first_refresh_latency: got %0d want 11", n); end
        for (int i = 0; i < 3; i++) begin
            wait_disp_start("idle_refresh", n);
            checks++; if (n !== 10) begin errors++; $display("FAIL refresh_interval: got %0d want 10", n); end
            checks++; if (disp_bank !== 1'b0 || wr_bank !== 1'b1 || disp_count !== '0) begin
                errors++; $display("FAIL idle_refresh_state: got bank %0b/%0b count %0d want 0/1/0", disp_bank, wr_bank, disp_count);
            end
        end
        step();
        checks++; if (disp_start !== 1'b0) begin errors++; $display("FAIL disp_start_width: got %0b want 0", disp_start); end
    endtask

    task automatic test_swap();
        int n;
        do_reset();
        wait_disp_start("swap_sync", n);
        wr_start = 1'b1; step(); wr_start = 1'b0;
        step(); step();
        wr_done = 1'b1; wr_count = CW'(37); step(); wr_done = 1'b0;
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL swap_pending_set: got %0b want 1", pending); end
        checks++; if (disp_bank !== 1'b0) begin errors++; $display("FAIL swap_early: got %0b want 0", disp_bank); end
        wait_disp_start("swap_refresh", n);
        checks++; if (disp_bank !== 1'b1 || wr_bank !== 1'b0) begin
            errors++; $display("FAIL swap_banks: got %0b/%0b want 1/0", disp_bank, wr_bank);
        end
        checks++; if (disp_count !== CW'(37)) begin errors++; $display("FAIL swap_count: got %0d want 37", disp_count); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL swap_pending_clr: got %0b want 0", pending); end
    endtask

    task automatic test_clamp();
        int n;
        do_reset();
        wait_disp_start("clamp_sync", n);
        write_frame(300);
        wait_disp_start("clamp_refresh", n);
        checks++; if (disp_count !== CW'(256)) begin errors++; $display("FAIL clamp_count: got %0d want 256", disp_count); end
        checks++; if (disp_bank !== 1'b1) begin errors++; $display("FAIL clamp_bank: got %0b want 1", disp_bank); end
    endtask

    task automatic test_frame_drop();
        int n;
        int starts;
        int drops;
        do_reset();
        wait_disp_start("drop_sync", n);
        disp_ready = 1'b0;
        write_frame(5);
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL drop_first_pending: got %0b want 1", pending); end
        wr_start = 1'b1; step(); wr_start = 1'b0;
        checks++; if (frame_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %0b want 1", frame_drop); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL drop_pending_clr: got %0b want 0", pending); end
        step();
        checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL drop_width: got %0b want 0", frame_drop); end
        wr_done = 1'b1; wr_count = CW'(9); step(); wr_done = 1'b0;
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL drop_second_pending: got %0b want 1", pending); end
        starts = 0;
        drops  = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (disp_start === 1'b1) starts++;
            if (frame_drop === 1'b1) drops++;
        end
        checks++; if (starts !== 0 || drops !== 0) begin
            errors++; $display("FAIL drop_stalled: got %0d starts %0d drops want 0 0", starts, drops);
        end
        checks++; if (disp_bank !== 1'b0) begin errors++; $display("FAIL drop_stalled_bank: got %0b want 0", disp_bank); end
        disp_ready = 1'b1;
        wait_disp_start("drop_resume", n);
        checks++; if (disp_count !== CW'(9) || disp_bank !== 1'b1 || pending !== 1'b0) begin
            errors++; $display("FAIL drop_resume: got count %0d bank %0b pend %0b want 9 1 0", disp_count, disp_bank, pending);
        end
        wait_disp_start("drop_resend", n);
        checks++; if (disp_count !== CW'(9) || disp_bank !== 1'b1) begin
            errors++; $display("FAIL drop_single_swap: got count %0d bank %0b want 9 1", disp_count, disp_bank);
        end
    endtask

    task automatic test_tick_while_writing();
        int n;
        do_reset();
        wait_disp_start("tww_sync", n);
        write_frame(15);
        wait_disp_start("tww_first", n);
        checks++; if (disp_count !== CW'(15) || disp_bank !== 1'b1) begin
            errors++; $display("FAIL tww_first_swap: got count %0d bank %0b want 15 1", disp_count, disp_bank);
        end
        wr_start = 1'b1; step(); wr_start = 1'b0;
        wait_disp_start("tww_writing", n);
        checks++; if (disp_bank !== 1'b1 || wr_bank !== 1'b0 || disp_count !== CW'(15) || pending !== 1'b0) begin
            errors++; $display("FAIL tww_resend: got bank %0b/%0b count %0d pend %0b want 1/0 15 0", disp_bank, wr_bank, disp_count, pending);
        end
        wr_done = 1'b1; wr_count = CW'(20); step(); wr_done = 1'b0;
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL tww_pending: got %0b want 1", pending); end
        wait_disp_start("tww_swap", n);
        checks++; if (disp_bank !== 1'b0 || wr_bank !== 1'b1 || disp_count !== CW'(20)) begin
            errors++; $display("FAIL tww_swap: got bank %0b/%0b count %0d want 0/1 20", disp_bank, wr_bank, disp_count);
        end
    endtask

    task automatic test_swap_vs_start();
        int n;
        do_reset();
        wait_disp_start("svs_sync", n);
        disp_ready = 1'b0;
        write_frame(3);
        repeat (12) step();
        disp_ready = 1'b1;
        wr_start   = 1'b1;
        step();
        wr_start = 1'b0;
        checks++; if (disp_start !== 1'b1) begin errors++; $display("FAIL svs_start: got %0b want 1", disp_start); end
        checks++; if (disp_bank !== 1'b1 || wr_bank !== 1'b0 || disp_count !== CW'(3)) begin
            errors++; $display("FAIL svs_swap: got bank %0b/%0b count %0d want 1/0 3", disp_bank, wr_bank, disp_count);
        end
        checks++; if (frame_drop !== 1'b0 || pending !== 1'b0) begin
            errors++; $display("FAIL svs_no_drop: got drop %0b pend %0b want 0 0", frame_drop, pending);
        end
        step();
        wr_done = 1'b1; wr_count = CW'(7); step(); wr_done = 1'b0;
        checks++; if (pending !== 1'b1 || disp_bank !== 1'b1) begin
            errors++; $display("FAIL svs_complete: got pend %0b bank %0b want 1 1", pending, disp_bank);
        end
        wait_disp_start("svs_next", n);
        checks++; if (disp_bank !== 1'b0 || disp_count !== CW'(7)) begin
            errors++; $display("FAIL svs_next_swap: got bank %0b count %0d want 0 7", disp_bank, disp_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        do_reset();
        step();
        wr_start = 1'b1; step(); wr_start = 1'b0;
        RESET = 1'b1; step(); RESET = 1'b0;
        wr_done = 1'b1; wr_count = CW'(50); step(); wr_done = 1'b0;
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rmf_pending: got %0b want 0", pending); end
        wait_disp_start("rmf_refresh", n);
        checks++; if (disp_bank !== 1'b0 || wr_bank !== 1'b1 || disp_count !== '0) begin
            errors++; $display("FAIL rmf_state: got bank %0b/%0b count %0d want 0/1 0", disp_bank, wr_bank, disp_count);
        end
    endtask

    task automatic test_blank_timeout();
        int n;
        do_reset();
        wait_disp_start("bto_sync", n);
        write_frame(12);
        wait_disp_start("bto_swap", n);
        checks++; if (disp_count !== CW'(12)) begin errors++; $display("FAIL bto_swap_count: got %0d want 12", disp_count); end
        for (int i = 1; i <= 2; i++) begin
            wait_disp_start("bto_idle", n);
            checks++; if (disp_count !== CW'(12)) begin errors++; $display("FAIL bto_idle_%0d: got %0d want 12", i, disp_count); end
        end
        wait_disp_start("bto_third", n);
        checks++; if (disp_count !== CW'(EXP_BLANK_COUNT)) begin
            errors++; $display("FAIL bto_third: got %0d want %0d", disp_count, EXP_BLANK_COUNT);
        end
        wait_disp_start("bto_fourth", n);
        checks++; if (disp_count !== CW'(EXP_BLANK_COUNT)) begin
            errors++; $display("FAIL bto_hold: got %0d want %0d", disp_count, EXP_BLANK_COUNT);
        end
        write_frame(4);
        wait_disp_start("bto_restore", n);
        checks++; if (disp_count !== CW'(4) || disp_bank !== 1'b0) begin
            errors++; $display("FAIL bto_restore: got count %0d bank %0b want 4 0", disp_count, disp_bank);
        end
    endtask

    initial begin
        test_reset();
        test_swap();
        test_clamp();
        test_frame_drop();
        test_tick_while_writing();
        test_swap_vs_start();
        test_reset_mid_frame();
        test_blank_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
